pll_lock_ctrl: RTL

Lock supervisor for the system PLL, running on the PLL reference clock. It drives the PLL's `rst` input and consumes the PLL's asynchronous `locked` output. It holds the downstream core in reset until lock has been continuously stable for a programmable time. It re-resets the PLL on lock timeout or lock loss, and on software request.

---
 rtl/pll_ctrl_pkg.sv | 17 +
 rtl/sync2.sv | 24 ++
 rtl/pll_lock_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and default timing constants for the PLL lock supervisor.
// Defaults assume a 50 MHz reference clock.
package pll_ctrl_pkg;

    typedef enum logic [1:0] {
        StPllRst   = 2'd0,
        StWaitLock = 2'd1,
        StStable   = 2'd2,
        StRun      = 2'd3
    } pll_state_t;

    localparam int unsigned DefRstCycles    = 16;
    localparam int unsigned DefLockTimeout  = 50000;  // 1 ms
    localparam int unsigned DefStableCycles = 1024;
    localparam int unsigned DefCntW         = 8;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for a single asynchronous level, reset value 0.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL lock supervisor: pulses pll_rst, waits for stable lock, then releases the core.
// Define PLL_LOCK_CTRL_STATS_EN to build the retry/loss statistics counters.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = DefRstCycles,
    parameter int unsigned LOCK_TIMEOUT  = DefLockTimeout,
    parameter int unsigned STABLE_CYCLES = DefStableCycles,
    parameter int unsigned CNT_W         = DefCntW
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    input  logic             restart,
    output logic             pll_rst,
    output logic             core_reset,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int unsigned MaxA      = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MaxCycles = (MaxA > STABLE_CYCLES) ? MaxA : STABLE_CYCLES;
    localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    localparam logic [TimerW-1:0] RstLast     = TimerW'(RST_CYCLES - 1);
    localparam logic [TimerW-1:0] TimeoutLast = TimerW'(LOCK_TIMEOUT - 1);
    localparam logic [TimerW-1:0] StableLast  = TimerW'(STABLE_CYCLES - 1);

    pll_state_t        state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              locked_s;
    logic              pll_rst_q, core_reset_q, ready_q;

    sync2 u_sync_locked (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = StPllRst;
        end else begin
            unique case (state_q)
                StPllRst: begin
                    if (timer_q == RstLast) state_d = StWaitLock;
                end
                StWaitLock: begin
                    if (locked_s)                    state_d = StStable;
                    else if (timer_q == TimeoutLast) state_d = StPllRst;
                end
                StStable: begin
                    if (!locked_s)                  state_d = StWaitLock;
                    else if (timer_q == StableLast) state_d = StRun;
                end
                StRun: begin
                    if (!locked_s) state_d = StPllRst;
                end
                default: state_d = StPllRst;
            endcase
        end
        // A restart inside PLLRST must also rewind the pulse timer.
        timer_d = (restart || (state_d != state_q)) ? '0 : timer_q + 1'b1;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q      <= StPllRst;
            timer_q      <= '0;
            pll_rst_q    <= 1'b1;
            core_reset_q <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pll_rst_q    <= (state_d == StPllRst);
            core_reset_q <= (state_d != StRun);
            ready_q      <= (state_d == StRun);
        end
    end

    assign pll_rst    = pll_rst_q;
    assign core_reset = core_reset_q;
    assign ready      = ready_q;
    assign state      = state_q;

`ifdef PLL_LOCK_CTRL_STATS_EN
    logic             retry_inc, loss_inc;
    logic [CNT_W-1:0] retry_q, loss_q;

    // Restart-driven entries into PLLRST are deliberately not counted.
    assign retry_inc = !restart && (state_q == StWaitLock) && (state_d == StPllRst);
    assign loss_inc  = !restart && (state_q == StRun) && (state_d == StPllRst);

    always_ff @(posedge refclk) begin
        if (rst) begin
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            if (retry_inc && (retry_q != '1)) retry_q <= retry_q + 1'b1;
            if (loss_inc && (loss_q != '1))   loss_q  <= loss_q + 1'b1;
        end
    end

    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;
`else
    assign retry_cnt = '0;
    assign loss_cnt  = '0;
`endif

endmodule
